// File: rtl/nonce_sweep_controller_pkg.sv
// Shared types and widths for the nonce sweep controller and its SHA pass waiter.
package sha_ctrl_pkg;

    localparam int unsigned HDR_W                  = 608;
    localparam int unsigned NONCE_W                = 32;
    localparam int unsigned DIGEST_W               = 256;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1023;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_H1_GO   = 3'd1,
        S_H1_WAIT = 3'd2,
        S_H2_GO   = 3'd3,
        S_H2_WAIT = 3'd4,
        S_CMP     = 3'd5,
        S_FIN     = 3'd6
    } state_t;

endpackage

// File: rtl/nonce_sweep_controller_waiter.sv
// Completion detect and stall timeout for one SHA pass; reused for both passes.
module sha_pass_waiter
    import sha_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic arm_clear,
    input  logic waiting,
    input  logic sha_complete,
    output logic pass_done,
    output logic timed_out
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    // Counter holds (wait cycles - 1), so this fires on the TIMEOUT_CYCLES-th wait cycle.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          armed;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || arm_clear) begin
            armed    <= 1'b0;
            wait_cnt <= '0;
        end else if (waiting) begin
            // A complete level left over from the previous pass must drop before it counts.
            if (!sha_complete) armed <= 1'b1;
            if (!timed_out) wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign pass_done = waiting && armed && sha_complete;
    assign timed_out = waiting && (wait_cnt == LAST);

endmodule

// File: rtl/nonce_sweep_controller.sv
// Drives one SHA engine through double-SHA-256 of a block header over a nonce range,
// stopping on the first digest below target, range end, abort or engine stall.
module nonce_sweep_controller
    import sha_ctrl_pkg::*;
#(
    parameter int unsigned MSG_SIZE       = 640,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [HDR_W-1:0]    header_in,
    input  logic [NONCE_W-1:0]  nonce_start,
    input  logic [NONCE_W-1:0]  nonce_end,
    input  logic [DIGEST_W-1:0] target,
    output logic [MSG_SIZE-1:0] sha_msg,
    output logic                sha_begin,
    input  logic                sha_complete,
    input  logic [DIGEST_W-1:0] sha_digest,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic                timeout_err,
    output logic [NONCE_W-1:0]  golden_nonce,
    output logic [DIGEST_W-1:0] golden_hash,
    output logic [CNT_W-1:0]    hashes_done
);

    localparam int unsigned PAD_W = MSG_SIZE - DIGEST_W;

    state_t              state, state_nx;
    logic [HDR_W-1:0]    header_reg;
    logic [NONCE_W-1:0]  nonce_end_reg;
    logic [DIGEST_W-1:0] target_reg;
    logic [NONCE_W-1:0]  cur_nonce;
    logic [NONCE_W-1:0]  nonce_next;
    logic [DIGEST_W-1:0] digest2;
    logic                hit;
    logic                waiting;
    logic                arm_clear;
    logic                pass_done;
    logic                timed_out;

    assign waiting    = (state == S_H1_WAIT) || (state == S_H2_WAIT);
    assign arm_clear  = (state == S_H1_GO) || (state == S_H2_GO);
    assign sha_begin  = arm_clear;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FIN);
    assign hit        = (digest2 < target_reg);
    assign nonce_next = cur_nonce + NONCE_W'(1);

    sha_pass_waiter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_waiter (
        .clk         (clk),
        .rst         (rst),
        .arm_clear   (arm_clear),
        .waiting     (waiting),
        .sha_complete(sha_complete),
        .pass_done   (pass_done),
        .timed_out   (timed_out)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_H1_GO;
            S_H1_GO:   state_nx = S_H1_WAIT;
            S_H1_WAIT: if (timed_out) state_nx = S_FIN;
                       else if (pass_done) state_nx = S_H2_GO;
            S_H2_GO:   state_nx = S_H2_WAIT;
            S_H2_WAIT: if (timed_out) state_nx = S_FIN;
                       else if (pass_done) state_nx = S_CMP;
            S_CMP:     if (hit || cur_nonce == nonce_end_reg) state_nx = S_FIN;
                       else state_nx = S_H1_GO;
            default:   state_nx = S_IDLE;
        endcase
        // FIN already terminates; letting abort hold it there would repeat done.
        if (abort && state != S_IDLE && state != S_FIN) state_nx = S_FIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            header_reg    <= '0;
            nonce_end_reg <= '0;
            target_reg    <= '0;
            cur_nonce     <= '0;
            digest2       <= '0;
            sha_msg       <= '0;
            found         <= 1'b0;
            timeout_err   <= 1'b0;
            golden_nonce  <= '0;
            golden_hash   <= '0;
            hashes_done   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (start) begin
                    header_reg    <= header_in;
                    nonce_end_reg <= nonce_end;
                    target_reg    <= target;
                    cur_nonce     <= nonce_start;
                    sha_msg       <= {header_in, nonce_start};
                    found         <= 1'b0;
                    timeout_err   <= 1'b0;
                    golden_nonce  <= '0;
                    golden_hash   <= '0;
                    hashes_done   <= '0;
                end
                S_H1_WAIT: if (state_nx == S_H2_GO) sha_msg <= {{PAD_W{1'b0}}, sha_digest};
                S_H2_WAIT: if (state_nx == S_CMP) digest2 <= sha_digest;
                S_CMP: if (!abort) begin
                    if (hashes_done != '1) hashes_done <= hashes_done + CNT_W'(1);
                    if (hit) begin
                        found        <= 1'b1;
                        golden_nonce <= cur_nonce;
                        golden_hash  <= digest2;
                    end else if (state_nx == S_H1_GO) begin
                        cur_nonce <= nonce_next;
                        sha_msg   <= {header_reg, nonce_next};
                    end
                end
                default: ;
            endcase
            if (timed_out && !abort) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nonce_sweep_controller.sv
// Self-checking bench: behavioural SHA engine stand-in plus a sweep-level reference model.
module tb_nonce_sweep_controller;

    localparam int SHA_LAT = 70;
    localparam logic [255:0] MIX = 256'h9E3779B97F4A7C15F39CC0605CEDC8341082276BF3A27251F86C6A11D0C18E95;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [607:0] header_in = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic [255:0] target = '0;
    logic [639:0] sha_msg;
    logic         sha_begin;
    logic         sha_complete = 1'b0;
    logic [255:0] sha_digest = '0;
    logic         busy, done, found, timeout_err;
    logic [31:0]  golden_nonce;
    logic [255:0] golden_hash;
    logic [31:0]  hashes_done;

    always #5 clk = ~clk;

    nonce_sweep_controller #(
        .MSG_SIZE(640),
        .TIMEOUT_CYCLES(100),
        .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .header_in(header_in), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .sha_msg(sha_msg), .sha_begin(sha_begin),
        .sha_complete(sha_complete), .sha_digest(sha_digest), .busy(busy),
        .done(done), .found(found), .timeout_err(timeout_err),
        .golden_nonce(golden_nonce), .golden_hash(golden_hash), .hashes_done(hashes_done)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [639:0] begin_q[$];
    int           begin_cyc_q[$];

    // 0: normal, 1: complete held high from previous pass for a while, 2: never completes
    int           sha_mode = 0;
    int           lat_left = 0;
    int           stale_left = 0;
    logic [639:0] cap_msg = '0;

    function automatic logic [255:0] fake_sha(input logic [639:0] m);
        logic [255:0] a;
        a = m[255:0] ^ m[511:256] ^ {128'd0, m[639:512]};
        a = (a + 256'd1) * MIX;
        a = a ^ (a >> 97) ^ (a << 61);
        return a;
    endfunction

    function automatic logic [255:0] exp_d2(input logic [607:0] h, input logic [31:0] n);
        return fake_sha({384'd0, fake_sha({h, n})});
    endfunction

    function automatic logic [607:0] rand_header();
        logic [607:0] h;
        for (int i = 0; i < 19; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sha_begin) begin
            begin_q.push_back(sha_msg);
            begin_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            sha_complete <= 1'b0;
            lat_left     <= 0;
            stale_left   <= 0;
        end else if (sha_begin) begin
            cap_msg    <= sha_msg;
            lat_left   <= SHA_LAT;
            stale_left <= (sha_mode == 1) ? 5 : 0;
            if (sha_mode != 1) sha_complete <= 1'b0;
        end else if (sha_mode == 2) begin
            sha_complete <= 1'b0;
        end else if (lat_left > 0) begin
            lat_left <= lat_left - 1;
            if (stale_left > 0) stale_left <= stale_left - 1;
            else sha_complete <= 1'b0;
            if (lat_left == 1) begin
                sha_complete <= 1'b1;
                sha_digest   <= fake_sha(cap_msg);
            end
        end
    end

    task automatic start_sweep(input logic [607:0] h, input logic [31:0] s, input logic [31:0] e,
                               input logic [255:0] t);
        begin_q.delete();
        begin_cyc_q.delete();
        @(negedge clk);
        header_in = h; nonce_start = s; nonce_end = e; target = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++; if (found !== 1'b0 || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got %b%b want 00", found, timeout_err); end
        tests_run++; if (sha_msg !== '0 || sha_begin !== 1'b0) begin tests_failed++; $display("FAIL reset_sha got msg %h begin %b want 0", sha_msg, sha_begin); end
        tests_run++; if (hashes_done !== 32'd0 || golden_nonce !== 32'd0 || golden_hash !== '0) begin tests_failed++; $display("FAIL reset_results got %0d %h want 0", hashes_done, golden_nonce); end
    endtask

    task automatic test_single();
        bit ok;
        int d0;
        logic [639:0] m0, m1;
        sha_mode = 0;
        d0 = done_cnt;
        start_sweep('0, 32'd0, 32'd0, '1);
        tests_run++; if (sha_begin !== 1'b1) begin tests_failed++; $display("FAIL single_begin_latency got %b want 1", sha_begin); end
        wait_done(400, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_done_timeout got no done want done"); end
        repeat (2) @(negedge clk);
        m0 = (begin_q.size() > 0) ? begin_q[0] : '0;
        m1 = (begin_q.size() > 1) ? begin_q[1] : '0;
        tests_run++; if (begin_q.size() != 2) begin tests_failed++; $display("FAIL single_begins got %0d want 2", begin_q.size()); end
        tests_run++; if (m0 !== 640'd0) begin tests_failed++; $display("FAIL single_msg1 got %h want 0", m0); end
        tests_run++; if (m1 !== {384'd0, fake_sha(640'd0)}) begin tests_failed++; $display("FAIL single_msg2 got %h want %h", m1[255:0], fake_sha(640'd0)); end
        tests_run++; if (found !== 1'b1 || golden_nonce !== 32'd0) begin tests_failed++; $display("FAIL single_found got %b %h want 1 0", found, golden_nonce); end
        tests_run++; if (golden_hash !== exp_d2('0, 32'd0)) begin tests_failed++; $display("FAIL single_hash got %h want %h", golden_hash, exp_d2('0, 32'd0)); end
        tests_run++; if (hashes_done !== 32'd1) begin tests_failed++; $display("FAIL single_count got %0d want 1", hashes_done); end
        tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - d0); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after got %b want 0", busy); end
    endtask

    task automatic test_range();
        bit ok;
        logic [607:0] h;
        h = rand_header();
        start_sweep(h, 32'd5, 32'd7, '0);
        repeat (20) @(negedge clk);
        nonce_start = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1200, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL range_done_timeout got no done want done"); end
        repeat (2) @(negedge clk);
        tests_run++; if (begin_q.size() != 6) begin tests_failed++; $display("FAIL range_begins got %0d want 6", begin_q.size()); end
        for (int i = 0; i < 3 && 2*i+1 < begin_q.size(); i++) begin
            tests_run++; if (begin_q[2*i] !== {h, 32'd5 + 32'(i)}) begin tests_failed++; $display("FAIL range_msg1_%0d got nonce %h want %h", i, begin_q[2*i][31:0], 32'd5 + 32'(i)); end
            tests_run++; if (begin_q[2*i+1] !== {384'd0, fake_sha({h, 32'd5 + 32'(i)})}) begin tests_failed++; $display("FAIL range_msg2_%0d got %h", i, begin_q[2*i+1][255:0]); end
        end
        tests_run++; if (found !== 1'b0 || hashes_done !== 32'd3) begin tests_failed++; $display("FAIL range_result got found %b count %0d want 0 3", found, hashes_done); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [607:0] h;
        logic [31:0] n;
        h = rand_header();
        start_sweep(h, 32'hFFFF_FFFE, 32'h0000_0001, '0);
        wait_done(1500, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL wrap_done_timeout got no done want done"); end
        repeat (2) @(negedge clk);
        tests_run++; if (begin_q.size() != 8) begin tests_failed++; $display("FAIL wrap_begins got %0d want 8", begin_q.size()); end
        n = 32'hFFFF_FFFE;
        for (int i = 0; i < 4 && 2*i < begin_q.size(); i++) begin
            tests_run++; if (begin_q[2*i][31:0] !== n) begin tests_failed++; $display("FAIL wrap_nonce_%0d got %h want %h", i, begin_q[2*i][31:0], n); end
            n = n + 32'd1;
        end
        tests_run++; if (hashes_done !== 32'd4 || found !== 1'b0) begin tests_failed++; $display("FAIL wrap_result got count %0d found %b want 4 0", hashes_done, found); end
    endtask

    task automatic test_stale();
        bit ok;
        logic [607:0] h;
        int gap;
        h = rand_header();
        sha_mode = 1;
        start_sweep(h, 32'd9, 32'd9, '1);
        wait_done(600, ok);
        sha_mode = 0;
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL stale_done_timeout got no done want done"); end
        repeat (2) @(negedge clk);
        gap = (begin_cyc_q.size() > 1) ? begin_cyc_q[1] - begin_cyc_q[0] : 0;
        tests_run++; if (gap < SHA_LAT) begin tests_failed++; $display("FAIL stale_gap got %0d want >= %0d", gap, SHA_LAT); end
        tests_run++; if (begin_q.size() != 2 || begin_q[1] !== {384'd0, fake_sha({h, 32'd9})}) begin tests_failed++; $display("FAIL stale_msg2 got %0d begins", begin_q.size()); end
        tests_run++; if (found !== 1'b1 || golden_hash !== exp_d2(h, 32'd9)) begin tests_failed++; $display("FAIL stale_hash got %b %h want 1 %h", found, golden_hash, exp_d2(h, 32'd9)); end
    endtask

    task automatic test_timeout();
        bit ok;
        int delta;
        sha_mode = 2;
        start_sweep(rand_header(), 32'd0, 32'd3, '0);
        wait_done(400, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL timeout_done_missing got no done want done"); end
        repeat (2) @(negedge clk);
        sha_mode = 0;
        delta = (begin_cyc_q.size() > 0) ? done_cyc - begin_cyc_q[0] : -1;
        tests_run++; if (delta < 100 || delta > 101) begin tests_failed++; $display("FAIL timeout_latency got %0d want 100..101", delta); end
        tests_run++; if (timeout_err !== 1'b1 || found !== 1'b0) begin tests_failed++; $display("FAIL timeout_flags got err %b found %b want 1 0", timeout_err, found); end
        tests_run++; if (hashes_done !== 32'd0 || begin_q.size() != 1) begin tests_failed++; $display("FAIL timeout_count got %0d begins %0d want 0 1", hashes_done, begin_q.size()); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_busy got %b want 0", busy); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            bit ok;
            logic [607:0] h;
            logic [31:0] s, n, e_nonce, e_golden;
            logic [255:0] t, d, e_hash;
            int len, e_cnt;
            bit e_found;
            h = rand_header();
            s = (it == 0) ? 32'hFFFF_FFFF : $urandom;
            len = $urandom_range(0, 4);
            case ($urandom_range(0, 3))
                0: t = '0;
                1: t = '1;
                2: for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
                default: begin
                    d = exp_d2(h, s + 32'($urandom_range(0, len)));
                    t = (d == '1) ? d : d + 256'd1;
                end
            endcase
            e_found = 0; e_cnt = 0; e_golden = '0; e_hash = '0;
            for (int i = 0; i <= len; i++) begin
                n = s + 32'(i);
                d = exp_d2(h, n);
                e_cnt++;
                if (d < t) begin
                    e_found = 1; e_golden = n; e_hash = d;
                    break;
                end
            end
            start_sweep(h, s, s + 32'(len), t);
            wait_done(200 * (len + 2), ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand%0d_done_timeout got no done want done", it); end
            repeat (2) @(negedge clk);
            tests_run++; if (found !== e_found || golden_nonce !== e_golden || golden_hash !== e_hash) begin tests_failed++; $display("FAIL rand%0d_result got %b %h want %b %h", it, found, golden_nonce, e_found, e_golden); end
            tests_run++; if (hashes_done !== 32'(e_cnt) || begin_q.size() != 2 * e_cnt) begin tests_failed++; $display("FAIL rand%0d_count got %0d begins %0d want %0d", it, hashes_done, begin_q.size(), e_cnt); end
            tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_timeout_err got %b want 0", it, timeout_err); end
        end
    endtask

    task automatic test_abort();
        bit ok;
        start_sweep(rand_header(), 32'd0, 32'd10, '0);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (begin_q.size() >= 8) begin ok = 1; break; end
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL abort_reach_nonce3 got %0d begins want 8", begin_q.size()); end
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL abort_done got %b want 1", done); end
        tests_run++; if (hashes_done !== 32'd3 || found !== 1'b0) begin tests_failed++; $display("FAIL abort_result got count %0d found %b want 3 0", hashes_done, found); end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL abort_idle got busy %b done %b want 0 0", busy, done); end
    endtask

    task automatic test_reset_mid();
        int d0;
        start_sweep(rand_header(), 32'd0, 32'd20, '0);
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || sha_begin !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ctrl got %b%b%b want 000", busy, done, sha_begin); end
        tests_run++; if (sha_msg !== '0 || hashes_done !== 32'd0) begin tests_failed++; $display("FAIL rstmid_data got count %0d want 0", hashes_done); end
        tests_run++; if (found !== 1'b0 || timeout_err !== 1'b0 || golden_nonce !== 32'd0 || golden_hash !== '0) begin tests_failed++; $display("FAIL rstmid_results got %b%b %h want 0", found, timeout_err, golden_nonce); end
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        tests_run++; if (done_cnt != d0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_done got %0d pulses busy %b want 0 0", done_cnt - d0, busy); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_range();
        test_wrap();
        test_stale();
        test_timeout();
        test_random();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
